// File: rtl/rx_wb_pack_pkg.sv
// Shared constants, FSM state type and small helpers for the rx_wb_pack packer.
package rx_wb_pack_pkg;

  localparam int          RXWB_WORDS_PER_CH = 3;
  localparam logic [11:0] RXWB_PAT_W1       = 12'hdef;
  localparam logic [3:0]  RXWB_PAT_A        = 4'ha;
  localparam logic [3:0]  RXWB_PAT_B        = 4'hb;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } seq_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] m);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int b = 0; b < 16; b++) cnt = cnt + 5'(m[b]);
    return cnt;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [3:0] lowest16(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int b = 15; b >= 0; b--) idx = m[b] ? 4'(b) : idx;
    return idx;
  endfunction

endpackage

// File: rtl/rx_wb_pack_if.sv
// Sample-input, CPU read-side and status signals of rx_wb_pack grouped as one bundle.
interface rx_wb_pack_if
  import rx_wb_pack_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IN_WIDTH = 18,
  parameter int DEPTH    = 512
);
  localparam int LW = clog2(DEPTH) + 1;

  logic                    flush;
  logic [NCH-1:0]          ch_en;
  logic                    in_strobe;
  logic [NCH*IN_WIDTH-1:0] in_i;
  logic [NCH*IN_WIDTH-1:0] in_q;
  logic                    rd_pop;
  logic [15:0]             rd_dout;
  logic                    rd_valid;
  logic [LW-1:0]           fill_level;
  logic                    busy;
  logic                    overflow;
  logic [15:0]             drop_cnt;

  modport master (
    output flush, ch_en, in_strobe, in_i, in_q, rd_pop,
    input  rd_dout, rd_valid, fill_level, busy, overflow, drop_cnt
  );

  modport slave (
    input  flush, ch_en, in_strobe, in_i, in_q, rd_pop,
    output rd_dout, rd_valid, fill_level, busy, overflow, drop_cnt
  );
endinterface

// File: rtl/rx_wb_pack_fifo.sv
// Single-clock first-word-fall-through FIFO, DEPTH x 16, with level output and sync clear.
module rx_wb_pack_fifo
  import rx_wb_pack_pkg::*;
#(
  parameter int DEPTH = 512
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [15:0]           din,
  input  logic                  pop,
  output logic [15:0]           dout,
  output logic                  valid,
  output logic [clog2(DEPTH):0] level
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          do_push_s, do_pop_s;

  assign do_push_s = push && (level_r != LW'(DEPTH));
  assign do_pop_s  = pop && (level_r != '0);

  // Storage array, written only; pointers make stale contents invisible.
  always_ff @(posedge clk) begin
    if (do_push_s && !clr) mem[wr_ptr_r] <= din;
  end

  // Pointers and level; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign valid = (level_r != '0);
  assign dout  = valid ? mem[rd_ptr_r] : 16'd0;
  assign level = level_r;

endmodule

// File: rtl/rx_wb_pack.sv
// Multi-channel I/Q snapshot packer: atomic 3-words-per-channel frames into a FWFT FIFO.
// Build macro RX_WB_PATTERN_EN swaps sample data for frame-counter/channel test words.
module rx_wb_pack
  import rx_wb_pack_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IN_WIDTH = 18,
  parameter int DEPTH    = 512
)(
  input  logic          adc_clk,
  input  logic          adc_rst_n,
  rx_wb_pack_if.slave   bus
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int UB = IN_WIDTH - 16;
  localparam int XW = NCH * IN_WIDTH;

  seq_state_e          state_r, state_s;
  logic [XW-1:0]       i_r, q_r;
  logic [NCH-1:0]      rem_r, rem_next_s;
  logic [1:0]          sub_r;
  logic                overflow_r;
  logic [15:0]         drop_cnt_r;
  logic [LW-1:0]       level_s, free_s;
  logic [4:0]          k_s;
  logic [6:0]          need_s;
  logic                strobe_live_s, room_s, accept_s, drop_s, frame_end_s, push_s;
  logic [3:0]          cur_s;
  logic [15:0]         cur_oh_s, word_s;
  logic [IN_WIDTH-1:0] i_arr_s [16];
  logic [IN_WIDTH-1:0] q_arr_s [16];
  logic [IN_WIDTH-1:0] sel_i_s, sel_q_s;

  // Admission: a frame is taken only whole, so the free space must cover all of it.
  assign k_s           = popcount16(16'(bus.ch_en));
  assign need_s        = 7'(k_s) * 7'(RXWB_WORDS_PER_CH);
  assign free_s        = LW'(DEPTH) - level_s;
  assign room_s        = 32'(free_s) >= 32'(need_s);
  assign strobe_live_s = bus.in_strobe && (k_s != 5'd0);
  assign accept_s      = strobe_live_s && (state_r == ST_IDLE) && room_s;
  assign drop_s        = strobe_live_s && !accept_s;

  assign cur_s       = lowest16(16'(rem_r));
  assign cur_oh_s    = 16'd1 << cur_s;
  assign rem_next_s  = rem_r & ~cur_oh_s[NCH-1:0];
  assign frame_end_s = (state_r == ST_SEQ) && (sub_r == 2'd2) && (rem_next_s == '0);

  for (genvar n = 0; n < 16; n++) begin : g_unpack
    if (n < NCH) begin : g_on
      assign i_arr_s[n] = i_r[n*IN_WIDTH +: IN_WIDTH];
      assign q_arr_s[n] = q_r[n*IN_WIDTH +: IN_WIDTH];
    end else begin : g_off
      assign i_arr_s[n] = '0;
      assign q_arr_s[n] = '0;
    end
  end
  assign sel_i_s = i_arr_s[cur_s];
  assign sel_q_s = q_arr_s[cur_s];

  // FSM state register.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n)   state_r <= ST_IDLE;
    else if (bus.flush) state_r <= ST_IDLE;
    else              state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s)    state_s = ST_SEQ;  else state_s = ST_IDLE;
      ST_SEQ:  if (frame_end_s) state_s = ST_IDLE; else state_s = ST_SEQ;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: one FIFO write per SEQ cycle.
  always_comb begin
    push_s = 1'b0;
    case (state_r)
      ST_SEQ:  push_s = 1'b1;
      default: push_s = 1'b0;
    endcase
  end

  // Snapshot of the sample set and the remaining-channel scan.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      i_r <= '0; q_r <= '0; rem_r <= '0; sub_r <= 2'd0;
    end else if (bus.flush) begin
      rem_r <= '0; sub_r <= 2'd0;
    end else if (accept_s) begin
      i_r <= bus.in_i; q_r <= bus.in_q; rem_r <= bus.ch_en; sub_r <= 2'd0;
    end else if (push_s) begin
      if (sub_r == 2'd2) begin
        sub_r <= 2'd0;
        rem_r <= rem_next_s;
      end else begin
        sub_r <= sub_r + 2'd1;
      end
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      overflow_r <= 1'b0; drop_cnt_r <= 16'd0;
    end else if (bus.flush) begin
      overflow_r <= 1'b0; drop_cnt_r <= 16'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

`ifdef RX_WB_PATTERN_EN
  logic [15:0] frame_cnt_r;

  // Counter advances as a frame completes, so all words of a frame carry the same value.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n)       frame_cnt_r <= 16'd0;
    else if (bus.flush)   frame_cnt_r <= 16'd0;
    else if (frame_end_s) frame_cnt_r <= frame_cnt_r + 16'd1;
  end

  // Test-pattern word select.
  always_comb begin
    word_s = 16'd0;
    case (sub_r)
      2'd0:    word_s = frame_cnt_r;
      2'd1:    word_s = {cur_s, RXWB_PAT_W1};
      2'd2:    word_s = {cur_s, RXWB_PAT_A, cur_s, RXWB_PAT_B};
      default: word_s = 16'd0;
    endcase
  end
`else
  logic signed [UB-1:0] up_i_s, up_q_s;
  assign up_i_s = sel_i_s[IN_WIDTH-1:16];
  assign up_q_s = sel_q_s[IN_WIDTH-1:16];

  // Sample word select; upper fields are sign-extended to a byte each.
  always_comb begin
    word_s = 16'd0;
    case (sub_r)
      2'd0:    word_s = sel_i_s[15:0];
      2'd1:    word_s = sel_q_s[15:0];
      2'd2:    word_s = {8'(up_i_s), 8'(up_q_s)};
      default: word_s = 16'd0;
    endcase
  end
`endif

  rx_wb_pack_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (adc_clk),
    .rst_n (adc_rst_n),
    .clr   (bus.flush),
    .push  (push_s),
    .din   (word_s),
    .pop   (bus.rd_pop),
    .dout  (bus.rd_dout),
    .valid (bus.rd_valid),
    .level (level_s)
  );

  assign bus.fill_level = level_s;
  assign bus.busy       = (state_r == ST_SEQ);
  assign bus.overflow   = overflow_r;
  assign bus.drop_cnt   = drop_cnt_r;

endmodule
